// File: rtl/delay_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pkg
//  Description : Shared types and constants for the multi-channel delay
//                timer: channel state encoding, mode encoding and the
//                legacy default counter width / reset period.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_pkg;

    // Channel state. The FSM stores states as fixed-width constants so the
    // register encoding stays stable for legacy netlists and formal scripts.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // Channel mode bit
    localparam logic c_mode_oneshot  = 1'b0;
    localparam logic c_mode_periodic = 1'b1;

    // Legacy single-channel counter defaults
    localparam int c_def_cbits = 11;
    localparam int c_def_n_rst = 1250;

endpackage : delay_pkg
`default_nettype wire

// File: rtl/multi_delay_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : multi_delay_timer_if
//  Description : Control/status bundle of the multi-channel delay timer.
//                master : configuration/control side (drives cfg/start/stop)
//                slave  : the timer itself (drives sig/busy/flg/err)
//  Ports       : cfg_we, cfg_ch, cfg_period, cfg_periodic  - config write
//                start, stop                               - per-channel ctrl
//                sig, busy, flg, err                       - per-channel status
//  Revision    : 1.0 - initial release
// ============================================================================
interface multi_delay_timer_if #(
    parameter int NCH   = 4,
    parameter int CBITS = 11
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             cfg_we;
    logic [CHW-1:0]   cfg_ch;
    logic [CBITS-1:0] cfg_period;
    logic             cfg_periodic;
    logic [NCH-1:0]   start;
    logic [NCH-1:0]   stop;
    logic [NCH-1:0]   sig;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   flg;
    logic [NCH-1:0]   err;

    modport master (
        output cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop,
        input  sig, busy, flg, err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop,
        output sig, busy, flg, err
    );

endinterface : multi_delay_timer_if
`default_nettype wire

// File: rtl/delay_chan.sv
`default_nettype none
// ============================================================================
//  Module      : delay_chan
//  Description : One programmable delay channel. Holds counter, period, mode
//                and IDLE/RUN state; raises o_sig while running with
//                cnt == period. Carries the per-channel safety assertions.
//  Ports       : clk, rst            - clock, async active-high reset
//                i_cfg_we            - config write aimed at this channel
//                i_cfg_period/mode   - new period / periodic bit
//                i_start, i_stop     - start/restart, stop requests
//                o_sig, o_busy       - expiry pulse, channel running
//                o_flg, o_err        - counting (cnt<period), cnt>period
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_chan
    import delay_pkg::*;
#(
    parameter int CBITS = c_def_cbits,
    parameter int N_RST = c_def_n_rst
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_cfg_we,
    input  wire logic [CBITS-1:0] i_cfg_period,
    input  wire logic             i_cfg_periodic,
    input  wire logic             i_start,
    input  wire logic             i_stop,
    output logic                  o_sig,
    output logic                  o_busy,
    output logic                  o_flg,
    output logic                  o_err
);

    localparam logic [CBITS-1:0] c_period_rst = CBITS'(N_RST);

    logic [0:0]       r_state;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] r_period;
    logic             r_periodic;

    // Any config write clears the counter, which keeps cnt <= period even
    // when the new period is shorter than the current count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_run;
            r_cnt      <= '0;
            r_period   <= c_period_rst;
            r_periodic <= c_mode_periodic;
        end else begin
            if (i_cfg_we) begin
                r_period   <= i_cfg_period;
                r_periodic <= i_cfg_periodic;
            end
            if (i_stop) begin
                r_state <= c_st_idle;
                r_cnt   <= '0;
            end else if (i_start || i_cfg_we) begin
                if (i_start) begin
                    r_state <= c_st_run;
                end
                r_cnt <= '0;
            end else if (r_state == c_st_run) begin
                if (r_cnt == r_period) begin
                    r_cnt <= '0;
                    if (r_periodic == c_mode_oneshot) begin
                        r_state <= c_st_idle;
                    end
                end else begin
                    r_cnt <= r_cnt + CBITS'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        o_busy = (r_state == c_st_run);
        o_sig  = o_busy && (r_cnt == r_period);
        o_flg  = o_busy && (r_cnt <  r_period);
        o_err  = (r_cnt > r_period);
    end

    a_no_err: assert property (@(posedge clk) disable iff (rst) !o_err);
    a_sig_busy: assert property (@(posedge clk) disable iff (rst) o_sig |-> o_busy);
    a_flg_sig_excl: assert property (@(posedge clk) disable iff (rst) !(o_flg && o_sig));

endmodule : delay_chan
`default_nettype wire

// File: rtl/multi_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : multi_delay_timer
//  Description : NCH independent programmable delay channels. Out of reset
//                every channel free-runs with period N_RST (legacy single
//                counter behaviour). The top only decodes cfg_ch into
//                per-channel write enables; writes to cfg_ch >= NCH are
//                ignored.
//  Ports       : clk  - clock (posedge)
//                rst  - asynchronous active-high reset
//                bus  - multi_delay_timer_if.slave control/status bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module multi_delay_timer
    import delay_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CBITS = c_def_cbits,
    parameter int N_RST = c_def_n_rst
) (
    input  wire logic          clk,
    input  wire logic          rst,
    multi_delay_timer_if.slave bus
);

    logic [NCH-1:0] w_sig;
    logic [NCH-1:0] w_busy;
    logic [NCH-1:0] w_flg;
    logic [NCH-1:0] w_err;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic w_we;

        // Out-of-range channel indices match no instance and are dropped.
        assign w_we = bus.cfg_we && (32'(bus.cfg_ch) == gi);

        delay_chan #(
            .CBITS (CBITS),
            .N_RST (N_RST)
        ) u_chan (
            .clk            (clk),
            .rst            (rst),
            .i_cfg_we       (w_we),
            .i_cfg_period   (bus.cfg_period),
            .i_cfg_periodic (bus.cfg_periodic),
            .i_start        (bus.start[gi]),
            .i_stop         (bus.stop[gi]),
            .o_sig          (w_sig[gi]),
            .o_busy         (w_busy[gi]),
            .o_flg          (w_flg[gi]),
            .o_err          (w_err[gi])
        );
    end

    assign bus.sig  = w_sig;
    assign bus.busy = w_busy;
    assign bus.flg  = w_flg;
    assign bus.err  = w_err;

endmodule : multi_delay_timer
`default_nettype wire

// File: doc/multi_delay_timer.md
# multi_delay_timer

Parametrised multi-channel programmable delay timer, the generalised successor of the single fixed-period delay counter. Each of NCH channels holds its own period and mode (periodic or one-shot), can be started, stopped and reconfigured at run time, and raises a one-cycle expiry pulse. Out of reset every channel free-runs with the legacy fixed period, so the block drops in where the single-channel counter was used. It sits between the control/configuration logic and any consumer of timed ticks, and carries embedded safety assertions for formal checking.

## Interface
- NCH, 4, number of independent channels (≥1)
- CBITS, 11, counter and period width
- N_RST, 1250, period loaded into every channel at reset (must fit in CBITS)
- CHW, derived, max(1, $clog2(NCH)), channel index width

- clk  in  1  clock, all state on posedge
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CHW  target channel of write (values ≥ NCH ignored)
- cfg_period  in  CBITS  new period
- cfg_periodic  in  1  new mode: 1 periodic, 0 one-shot
- start  in  NCH  per-channel start/restart request
- stop  in  NCH  per-channel stop request
- sig  out  NCH  expiry: high while channel RUN and cnt == period
- busy  out  NCH  channel in RUN
- flg  out  NCH  RUN and cnt < period
- err  out  NCH  cnt > period (must never assert)

## Operation
- Per channel: cnt[CBITS], period[CBITS], periodic bit, state {IDLE, RUN}.
- Reset (asynchronous): state RUN, cnt 0, period N_RST, periodic 1. Outputs then: sig 0, busy 1, flg 1 (0 if N_RST == 0, in which case sig 1), err 0.
- Priority per channel per cycle: rst > stop > start / cfg write > normal count.
- stop[i]: state IDLE, cnt 0.
- start[i]: state RUN, cnt 0 (restarts a running channel).
- cfg write to i: period/periodic take new values next cycle; cnt forced to 0; state unchanged unless start[i] same cycle (then RUN). Guarantees cnt ≤ period at all times.
- cfg write + stop same channel: config applied, channel IDLE.
- RUN, cnt < period: cnt + 1.
- RUN, cnt == period: sig high this cycle; next cycle cnt 0; periodic stays RUN, one-shot goes IDLE.
- IDLE: cnt held at 0; sig, flg, busy low.
- cnt never exceeds period, so no wrap-around; period 0 periodic gives sig high every RUN cycle.
- Channels fully independent; writes to one channel never disturb another.

## Timing
- sig, flg, err, busy combinational from registered state; no input-to-output combinational path.
- start at edge t: RUN, cnt 0 after t; sig at cycle t+P (P = period); periodic repeat interval P+1 cycles.
- After reset release, first sig at cycle N_RST, then every N_RST+1.
- One-shot: busy falls the cycle after sig.
- Embedded assertions, per channel: from the second cycle after reset onward err[i] == 0 (X G !err); sig[i] implies busy[i]; flg[i] and sig[i] never both high.

## Structure
- Package delay_pkg: state enum typedef (IDLE, RUN), mode constants, default CBITS/N_RST.
- Sub-module delay_chan (one channel: cnt, period, mode, FSM, per-channel assertions), instantiated NCH times in a generate loop; top level only decodes cfg_ch into per-channel write enables.

## Test plan
- Reset, NCH=4 defaults: all busy=1; sig[3:0] first high at cycle 1250, again at 2501; err always 0.
- cfg ch1 period 3 one-shot, then start[1] at t: sig[1] high only at t+3, busy[1] low from t+4, other channels undisturbed.
- Periodic ch0 period 5, stop[0] at cnt 2: busy[0] low next cycle, cnt 0, no sig until start[0]; after start, sig every 6 cycles.
- ch2 running at cnt 900 of 1250, cfg write period 10: cnt 0 next cycle, sig[2] 10 cycles later, err[2] never high.
- stop[3] and start[3] same cycle: channel IDLE; cfg_ch = 3 with period 0 periodic plus start: sig[3] high every cycle.
- Assert rst mid-count (asynchronous, between edges): outputs return to reset values immediately; cfg_ch ≥ NCH write (NCH=3) changes nothing.
